// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer game controller.
// State encoding, LFSR seed/taps and the default display saturation limit.
package reaction_pkg;

    localparam int CW = 14;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        GO,
        RESULT,
        FOUL
    } state_t;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam int          MAX_MS_DEF = 9999;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; also intended for the display blink pattern.
// A non-zero seed plus maximal-length taps keeps it out of the all-zero state.
module lfsr16
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= LFSR_SEED;
        end else begin
            r_q <= {r_q[14:0], ^(r_q & LFSR_TAPS)};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: random delay, GO indicator, millisecond reaction count.
// Optional best-time register enabled by defining REACTION_BEST_EN.
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int CLK_FREQ     = 100000000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_MS       = MAX_MS_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_start,
    input  logic          btn_react,
    output logic [CW-1:0] number,
    output logic          go_led,
    output logic          foul,
    output logic          busy
`ifdef REACTION_BEST_EN
    ,
    output logic [CW-1:0] best
`endif
);

    localparam int PRESC = CLK_FREQ / 1000;
    localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int TW    = (RAND_BITS + 1 > CW) ? RAND_BITS + 1 : CW;
    localparam logic [CW-1:0] MAXV = CW'(MAX_MS);

    logic [15:0]   w_lfsr;
    logic          w_unused;
    logic [2:0]    r_st_sync;
    logic [2:0]    r_rc_sync;
    logic          r_st_pulse;
    logic          r_rc_pulse;
    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic          w_clr;
    state_t        r_state;
    state_t        w_state_n;
    logic [CW-1:0] r_wcnt;
    logic [CW-1:0] w_wcnt_n;
    logic [CW-1:0] w_wnext;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_n;
    logic [TW-1:0] r_tgt;
    logic [TW-1:0] w_tgt_n;
    logic [CW-1:0] w_num_n;
    logic [CW-1:0] r_number;
    logic          r_go;
    logic          r_foul;
    logic          r_busy;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

    // Upper LFSR bits are reserved for the display blink pattern
    assign w_unused = ^(w_lfsr >> RAND_BITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st_sync  <= '0;
            r_rc_sync  <= '0;
            r_st_pulse <= 1'b0;
            r_rc_pulse <= 1'b0;
        end else begin
            r_st_sync  <= {r_st_sync[1:0], btn_start};
            r_rc_sync  <= {r_rc_sync[1:0], btn_react};
            r_st_pulse <= r_st_sync[1] & ~r_st_sync[2];
            r_rc_pulse <= r_rc_sync[1] & ~r_rc_sync[2];
        end
    end

    assign w_tick  = (r_presc == PW'(PRESC - 1));
    assign w_wnext = r_wcnt + 1'b1;

    always_comb begin
        w_state_n = r_state;
        w_wcnt_n  = r_wcnt;
        w_cnt_n   = r_cnt;
        w_tgt_n   = r_tgt;
        unique case (r_state)
            IDLE, RESULT, FOUL: begin
                if (r_st_pulse) begin
                    w_state_n = WAIT;
                    w_tgt_n   = TW'(MIN_DELAY_MS)
                              + TW'(w_lfsr[RAND_BITS-1:0]);
                    w_wcnt_n  = '0;
                end
            end
            WAIT: begin
                if (r_rc_pulse) begin
                    w_state_n = FOUL;
                end else if (w_tick) begin
                    w_wcnt_n = w_wnext;
                    if (TW'(w_wnext) >= r_tgt) begin
                        w_state_n = GO;
                        w_cnt_n   = '0;
                    end
                end
            end
            GO: begin
                // A press wins over a tick landing in the same clk
                if (r_rc_pulse) begin
                    w_state_n = RESULT;
                end else if (w_tick) begin
                    if (r_cnt >= MAXV - 1'b1) begin
                        w_cnt_n   = MAXV;
                        w_state_n = RESULT;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    assign w_clr   = (w_state_n != r_state)
                  && (w_state_n == WAIT || w_state_n == GO);
    assign w_num_n = (w_state_n == GO || w_state_n == RESULT)
                   ? w_cnt_n : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_presc  <= '0;
            r_wcnt   <= '0;
            r_cnt    <= '0;
            r_tgt    <= '0;
            r_number <= '0;
            r_go     <= 1'b0;
            r_foul   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_presc  <= (w_clr || w_tick) ? '0 : r_presc + 1'b1;
            r_wcnt   <= w_wcnt_n;
            r_cnt    <= w_cnt_n;
            r_tgt    <= w_tgt_n;
            r_number <= w_num_n;
            r_go     <= (w_state_n == GO);
            r_foul   <= (w_state_n == FOUL);
            r_busy   <= (w_state_n == WAIT) || (w_state_n == GO);
        end
    end

`ifdef REACTION_BEST_EN
    logic [CW-1:0] r_best;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best <= MAXV;
        end else if (r_state == GO && r_rc_pulse && r_cnt < r_best) begin
            r_best <= r_cnt;
        end
    end

    assign best = r_best;
`endif

    assign number = r_number;
    assign go_led = r_go;
    assign foul   = r_foul;
    assign busy   = r_busy;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer at 10 clk/ms with a short random delay.
// Define REACTION_BEST_EN to also exercise the best-time register.
module tb_reaction_timer;

    localparam int MAXT = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_start;
    logic        btn_react;
    logic [13:0] number;
    logic        go_led;
    logic        foul;
    logic        busy;
`ifdef REACTION_BEST_EN
    logic [13:0] best;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int    p;
        int    exp;
        string nm;
    } vec_t;

    vec_t tbl[8];

    // Shortened saturation limit keeps the timeout round brief
    reaction_timer #(
        .CLK_FREQ     (10000),
        .MIN_DELAY_MS (5),
        .RAND_BITS    (3),
        .MAX_MS       (MAXT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_react (btn_react),
        .number    (number),
        .go_led    (go_led),
        .foul      (foul),
        .busy      (busy)
`ifdef REACTION_BEST_EN
        ,
        .best      (best)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired, got none, expected event", nm);
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        tick(3);
        btn_start = 1'b0;
    endtask

    task automatic wait_go(output bit ok);
        int c;
        c  = 0;
        ok = 1'b0;
        while (c < 400 && !ok) begin
            @(posedge clk);
            #1;
            c++;
            if (go_led) ok = 1'b1;
        end
        if (!ok) bad("wait_go");
    endtask

    // p = clk from GO entry to the conditioned react pulse
    task automatic do_round(input int p, input int exp, input string nm);
        bit ok;
        press_start();
        wait_go(ok);
        if (ok) begin
            chk({nm, "_busy_go"}, int'(busy), 1);
            tick(p - 3);
            btn_react = 1'b1;
            tick(5);
            chk({nm, "_num"}, int'(number), exp);
            chk({nm, "_go"}, int'(go_led), 0);
            chk({nm, "_foul"}, int'(foul), 0);
            chk({nm, "_busy"}, int'(busy), 0);
            btn_react = 1'b0;
            tick(4);
            btn_react = 1'b1;
            tick(5);
            chk({nm, "_hold"}, int'(number), exp);
            btn_react = 1'b0;
            tick(3);
        end
    endtask

    initial begin
        bit ok;
        int c;
        int d;
        int ms;
        int gocnt;
        int distinct;
        bit seen[16];

        tbl[0] = '{p: 3,    exp: 0,   nm: "p3"};
        tbl[1] = '{p: 9,    exp: 0,   nm: "p9"};
        tbl[2] = '{p: 10,   exp: 1,   nm: "p10"};
        tbl[3] = '{p: 11,   exp: 1,   nm: "p11"};
        tbl[4] = '{p: 99,   exp: 9,   nm: "p99"};
        tbl[5] = '{p: 100,  exp: 10,  nm: "p100"};
        tbl[6] = '{p: 237,  exp: 23,  nm: "p237"};
        tbl[7] = '{p: 2995, exp: 299, nm: "p2995"};

        rst       = 1'b1;
        btn_start = 1'b0;
        btn_react = 1'b0;
        tick(3);
        chk("rst_num", int'(number), 0);
        chk("rst_go", int'(go_led), 0);
        chk("rst_foul", int'(foul), 0);
        chk("rst_busy", int'(busy), 0);
`ifdef REACTION_BEST_EN
        chk("rst_best", int'(best), MAXT);
`endif
        rst = 1'b0;
        tick(3);

        for (int i = 0; i < 8; i++) begin
            do_round(tbl[i].p, tbl[i].exp, tbl[i].nm);
        end

        press_start();
        c = 0;
        while (c < 20 && !busy) begin
            tick(1);
            c++;
        end
        if (!busy) bad("foul_wait");
        btn_react = 1'b1;
        tick(5);
        chk("foul_flag", int'(foul), 1);
        chk("foul_num", int'(number), 0);
        chk("foul_busy", int'(busy), 0);
        btn_react = 1'b0;
        gocnt = 0;
        for (int i = 0; i < 150; i++) begin
            tick(1);
            if (go_led) gocnt++;
        end
        chk("foul_no_go", gocnt, 0);
        chk("foul_stay", int'(foul), 1);
        press_start();
        tick(3);
        chk("foul_clear", int'(foul), 0);
        chk("foul_rebusy", int'(busy), 1);
        wait_go(ok);
        btn_react = 1'b1;
        tick(5);
        btn_react = 1'b0;
        tick(2);

        foreach (seen[k]) seen[k] = 1'b0;
        for (int r = 0; r < 50; r++) begin
            tick($urandom_range(0, 7));
            btn_start = 1'b1;
            c = 0;
            while (c < 20 && !busy) begin
                tick(1);
                c++;
            end
            btn_start = 1'b0;
            d = 0;
            while (d < 200 && !go_led) begin
                tick(1);
                d++;
            end
            ms = d / 10;
            n_cmp++;
            if (ms < 5 || ms > 12) begin
                n_bad++;
                $display("FAIL wait_range: got %0d ms, expected 5..12", ms);
            end else begin
                seen[ms] = 1'b1;
            end
            btn_react = 1'b1;
            tick(5);
            btn_react = 1'b0;
            tick(2);
        end
        distinct = 0;
        foreach (seen[k]) if (seen[k]) distinct++;
        chk("wait_distinct_ge4", int'(distinct >= 4), 1);

        press_start();
        wait_go(ok);
        tick(155);
        chk("go_live", int'(number), 15);
        c = 155;
        while (c < 4000 && go_led) begin
            tick(1);
            c++;
        end
        chk("tmo_cyc", c, MAXT * 10);
        chk("tmo_num", int'(number), MAXT);
        chk("tmo_go", int'(go_led), 0);
        chk("tmo_busy", int'(busy), 0);

        press_start();
        wait_go(ok);
        tick(20);
        chk("mid_go_pre", int'(go_led), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_num", int'(number), 0);
        chk("mid_rst_go", int'(go_led), 0);
        chk("mid_rst_busy", int'(busy), 0);
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("post_rst_num", int'(number), 0);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_go", int'(go_led), 0);

`ifdef REACTION_BEST_EN
        do_round(403, 40, "b40");
        chk("best_40", int'(best), 40);
        do_round(173, 17, "b17");
        do_round(303, 30, "b30");
        chk("best_17", int'(best), 17);
        press_start();
        wait_go(ok);
        c = 0;
        while (c < 4000 && go_led) begin
            tick(1);
            c++;
        end
        chk("best_tmo_num", int'(number), MAXT);
        chk("best_after_tmo", int'(best), 17);
        rst = 1'b1;
        tick(2);
        chk("best_rst", int'(best), MAXT);
        rst = 1'b0;
        tick(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Game controller directly upstream of the display stage; produces the 14-bit number the display renders.
- Player presses start; after a pseudo-random delay, the GO indicator lights.
- Block measures the time from GO to the react press in milliseconds, 0..9999.
- Early presses are flagged as fouls; the result is held until the next start.

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz; ms prescaler divides by CLK_FREQ/1000.
- MIN_DELAY_MS, 1000, minimum wait before GO, in ms.
- RAND_BITS, 11, number of LFSR bits added to MIN_DELAY_MS (max extra 2^RAND_BITS-1 ms).
- MAX_MS, 9999, saturation value of the reaction count (4-digit display limit).

Ports:
- clk  input  1  main clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- btn_start  input  1  raw start/retry button, asynchronous.
- btn_react  input  1  raw reaction button, asynchronous.
- number  output  14  value for the display stage, 0..9999.
- go_led  output  1  high while waiting for the reaction.
- foul  output  1  high after an early press.
- busy  output  1  high in WAIT or GO.

Behaviour:
- Reset values: state=IDLE, number=0, go_led=0, foul=0, busy=0, prescaler=0, LFSR=16'hACE1. Reset is effective immediately, including mid-round.
- Input conditioning:
  - Each button has a 2-flop synchronizer followed by a rising-edge detect, giving a one-clk pulse.
  - Latency from pin to pulse is 3 clk.
  - No debounce; only the first edge matters in each state.
- Millisecond tick:
  - Prescaler counts 0..CLK_FREQ/1000-1; tick is a 1-clk pulse on wrap.
  - Prescaler is cleared to 0 on entry to WAIT and on entry to GO, so the first tick lands exactly CLK_FREQ/1000 clk later.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every clk from reset.
  - Never reaches all-zero.
- State machine (registered outputs, update on the clk after the event):
  - IDLE: number=0. start pulse -> WAIT; target = MIN_DELAY_MS + lfsr[RAND_BITS-1:0]; wait count=0.
  - WAIT: busy=1, number=0.
    - Each tick increments wait count.
    - react pulse -> FOUL; react takes priority over target reached in the same clk.
    - wait count == target -> GO; reaction count=0.
  - GO: go_led=1, busy=1, number=live reaction count.
    - Each tick increments the count.
    - react pulse -> RESULT; number holds the count at the press. A tick in the same clk is not added.
    - If count reaches MAX_MS, it saturates and the FSM moves to RESULT with number=9999.
  - RESULT: number held, go_led=0. start pulse -> WAIT (new target); react pulses ignored.
  - FOUL: foul=1, number=0. start pulse -> WAIT; foul cleared on exit.
  - A start pulse in WAIT or GO is ignored.
- Widths:
  - Counters are 14 bits.
  - Target width is max(14, RAND_BITS+1) and must fit in 14 bits with the defaults.
  - All compares are unsigned.
- Accuracy: measured ms = floor(clk cycles from GO entry to react pulse / (CLK_FREQ/1000)).

Optional Feature:
- Macro: REACTION_BEST_EN.
- With the macro defined:
  - Adds a register best_ms (reset 9999) and output port best  output  14.
  - On entry to RESULT via a react press, if count < best_ms then best_ms = count. A MAX_MS timeout does not update best_ms.
  - best_ms survives rounds and is cleared only by rst.
- Without the macro: no best port and no register; behaviour is otherwise identical.

Decomposition:
- Package reaction_pkg:
  - State enum {IDLE, WAIT, GO, RESULT, FOUL}.
  - LFSR_SEED = 16'hACE1, LFSR tap mask.
  - Default MAX_MS.
- One natural sub-module: lfsr16 (clk, rst, q[15:0]), free-running, reused later for the display blink pattern.
- Synchronizer and edge detect stay inline.

Test Plan (CLK_FREQ=10000, i.e. 10 clk/ms; MIN_DELAY_MS=5; RAND_BITS=3):
- Reset mid-GO: assert rst while go_led=1 -> same-cycle number=0, go_led=0, busy=0; state IDLE after release.
- Normal round: start, wait for go_led, press react 237 clk after GO entry -> number=23 held in RESULT, foul=0; react pulses in RESULT leave number unchanged.
- Foul: start, press react before go_led rises -> foul=1, number=0, go_led never asserts; next start clears foul and busy=1.
- Timeout: start, never press react -> number saturates at 9999 after 99990 clk in GO, then RESULT, go_led=0.
- Delay range: 50 rounds with start at varied offsets -> WAIT duration always 5..12 ms, and at least 4 distinct values seen.
- REACTION_BEST_EN: rounds of 40, 17, 30 ms -> best=17; timeout round -> best stays 17; rst -> best=9999.
